// File: rtl/sync_pkg.sv
// Shared helpers for the Gray-pointer synchroniser: code conversions and a step-size test.
package sync_pkg;

    localparam int unsigned SYNC_STAGES_MAX = 4;
    localparam int unsigned PTR_W_MAX       = 32;

    // Gray codes are zero-extended, so conversion is independent of the pointer width.
    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
        logic [PTR_W_MAX-1:0] b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = int'(PTR_W_MAX) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic onehot0_or_one(input logic [PTR_W_MAX-1:0] v);
        return (v & (v - PTR_W_MAX'(1))) == '0;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-bit flop chain; kept free of logic so CDC tools recognise it as a synchroniser.
module sync_chain #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/sync_gray_ptr.sv
// Multi-channel Gray pointer synchroniser with binary conversion, update strobe and jump detection.
module sync_gray_ptr
    import sync_pkg::*;
#(
    parameter int unsigned ASIZE    = 4,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned CHANNELS = 1
) (
    input  logic                          rclk,
    input  logic                          rrst_n,
    input  logic [CHANNELS-1:0][ASIZE:0]  wptr,
    output logic [CHANNELS-1:0][ASIZE:0]  rq_wptr,
    output logic [CHANNELS-1:0][ASIZE:0]  rq_wptr_bin,
    output logic [CHANNELS-1:0]           rq_upd,
    input  logic [CHANNELS-1:0]           err_clr,
    output logic [CHANNELS-1:0]           err_jump
);

    localparam int unsigned PTR_W = ASIZE + 1;

    if (STAGES < 2 || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("sync_gray_ptr: STAGES must be in 2..%0d", SYNC_STAGES_MAX);
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("sync_gray_ptr: CHANNELS must be at least 1");
    end
    if (PTR_W > PTR_W_MAX) begin : g_bad_asize
        $error("sync_gray_ptr: pointer width exceeds %0d", PTR_W_MAX);
    end

    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
        logic [PTR_W-1:0] sync_q;
        logic [PTR_W-1:0] hist_q;
        logic [PTR_W-1:0] bin_q;
        logic [PTR_W-1:0] delta;
        logic             upd_q;
        logic             err_q;
        logic             step;
        logic             jump;

        sync_chain #(
            .WIDTH  (PTR_W),
            .STAGES (STAGES)
        ) u_chain (
            .rclk   (rclk),
            .rrst_n (rrst_n),
            .d      (wptr[c]),
            .q      (sync_q)
        );

        assign delta = sync_q ^ hist_q;
        assign step  = |delta;
        assign jump  = step && !onehot0_or_one(PTR_W_MAX'(delta));

        // Any change updates the binary view; multi-bit changes also latch the sticky error.
        always_ff @(posedge rclk or negedge rrst_n) begin
            if (!rrst_n) begin
                hist_q <= '0;
                bin_q  <= '0;
                upd_q  <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                hist_q <= sync_q;
                upd_q  <= step;
                if (step) begin
                    bin_q <= PTR_W'(gray2bin(PTR_W_MAX'(sync_q)));
                end
                if (jump) begin
                    err_q <= 1'b1;
                end else if (err_clr[c]) begin
                    err_q <= 1'b0;
                end
            end
        end

        assign rq_wptr[c]     = sync_q;
        assign rq_wptr_bin[c] = bin_q;
        assign rq_upd[c]      = upd_q;
        assign err_jump[c]    = err_q;
    end

endmodule

// File: tb/tb_sync_gray_ptr.sv
// Bench for sync_gray_ptr: delay-line model compared every cycle plus directed literal checks.
module tb_sync_gray_ptr;

    localparam int CH = 4;
    localparam int S  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH-1:0][4:0] wptr;
    logic [CH-1:0][4:0] rq_wptr;
    logic [CH-1:0][4:0] rq_wptr_bin;
    logic [CH-1:0]      rq_upd;
    logic [CH-1:0]      err_clr;
    logic [CH-1:0]      err_jump;

    logic [0:0][4:0] wptr_s;
    logic [0:0]      clr_s;
    logic [0:0][4:0] rq3, bin3, rq4, bin4;
    logic [0:0]      upd3, err3, upd4, err4;

    int total = 0;
    int bad   = 0;
    int cnt [CH];

    always #5 clk = ~clk;

    sync_gray_ptr #(.ASIZE(4), .STAGES(S), .CHANNELS(CH)) dut (
        .rclk(clk), .rrst_n(rst_n), .wptr(wptr), .rq_wptr(rq_wptr),
        .rq_wptr_bin(rq_wptr_bin), .rq_upd(rq_upd), .err_clr(err_clr), .err_jump(err_jump)
    );
    sync_gray_ptr #(.ASIZE(4), .STAGES(3), .CHANNELS(1)) dut3 (
        .rclk(clk), .rrst_n(rst_n), .wptr(wptr_s), .rq_wptr(rq3),
        .rq_wptr_bin(bin3), .rq_upd(upd3), .err_clr(clr_s), .err_jump(err3)
    );
    sync_gray_ptr #(.ASIZE(4), .STAGES(4), .CHANNELS(1)) dut4 (
        .rclk(clk), .rrst_n(rst_n), .wptr(wptr_s), .rq_wptr(rq4),
        .rq_wptr_bin(bin4), .rq_upd(upd4), .err_clr(clr_s), .err_jump(err4)
    );

    function automatic logic [4:0] gray(input int n);
        return 5'(n ^ (n >> 1));
    endfunction

    // Decode by searching the code table rather than by bit arithmetic.
    function automatic logic [4:0] g2b(input logic [4:0] g);
        for (int n = 0; n < 32; n++) begin
            if (gray(n) == g) return 5'(n);
        end
        return 5'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the synchronised value is the input seen S edges ago; events follow from its history.
    logic [4:0] m_dly  [CH][S];
    logic [4:0] m_prev [CH];
    logic [4:0] m_bin  [CH];
    logic       m_upd  [CH];
    logic       m_err  [CH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < S; k++) m_dly[c][k] <= 5'd0;
                m_prev[c] <= 5'd0;
                m_bin[c]  <= 5'd0;
                m_upd[c]  <= 1'b0;
                m_err[c]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                m_dly[c][0] <= wptr[c];
                for (int k = 1; k < S; k++) m_dly[c][k] <= m_dly[c][k-1];
                m_prev[c] <= m_dly[c][S-1];
                m_upd[c]  <= (m_dly[c][S-1] != m_prev[c]);
                if (m_dly[c][S-1] != m_prev[c]) m_bin[c] <= g2b(m_dly[c][S-1]);
                if ($countones(m_dly[c][S-1] ^ m_prev[c]) > 1) m_err[c] <= 1'b1;
                else if (err_clr[c]) m_err[c] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [CH-1:0][4:0] e_rq, e_bin;
        logic [CH-1:0]      e_upd, e_err;
        for (int c = 0; c < CH; c++) begin
            e_rq[c]  = m_dly[c][S-1];
            e_bin[c] = m_bin[c];
            e_upd[c] = m_upd[c];
            e_err[c] = m_err[c];
        end
        chk("model rq_wptr", 32'(rq_wptr), 32'(e_rq));
        chk("model rq_wptr_bin", 32'(rq_wptr_bin), 32'(e_bin));
        chk("model rq_upd", 32'(rq_upd), 32'(e_upd));
        chk("model err_jump", 32'(err_jump), 32'(e_err));
    end

    initial for (int c = 0; c < CH; c++) cnt[c] = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < CH; c++) if (rq_upd[c]) cnt[c] = cnt[c] + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        wptr    = '0;
        err_clr = '0;
        wptr_s  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base [CH];
        int waited;
        rst_n   = 1'b1;
        wptr    = '0;
        err_clr = '0;
        wptr_s  = '0;
        clr_s   = '0;
        #1 rst_n = 1'b0;
        wptr[0] = 5'b10110;

        // Reset hold, then release with a stable 3-bit-from-zero pointer.
        repeat (2) @(negedge clk);
        chk("rst rq_wptr", 32'(rq_wptr), 32'd0);
        chk("rst rq_wptr_bin", 32'(rq_wptr_bin), 32'd0);
        chk("rst rq_upd", 32'(rq_upd), 32'd0);
        chk("rst err_jump", 32'(err_jump), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel e1 rq", 32'(rq_wptr[0]), 32'd0);
        @(negedge clk);
        chk("rel e2 rq", 32'(rq_wptr[0]), 32'b10110);
        chk("rel e2 upd", 32'(rq_upd[0]), 32'd0);
        @(negedge clk);
        chk("rel e3 bin", 32'(rq_wptr_bin[0]), 32'b11011);
        chk("rel e3 upd", 32'(rq_upd[0]), 32'd1);
        chk("rel e3 err", 32'(err_jump[0]), 32'd1);
        @(negedge clk);
        chk("rel e4 upd", 32'(rq_upd[0]), 32'd0);

        // Full lap including the 31 -> 0 wrap.
        do_reset();
        base[0] = cnt[0];
        for (int n = 1; n <= 32; n++) begin
            wptr[0] = gray(n % 32);
            repeat (3) @(negedge clk);
            if (n == 5) chk("lap bin@5", 32'(rq_wptr_bin[0]), 32'd5);
        end
        repeat (4) @(negedge clk);
        chk("lap upd count", 32'(cnt[0] - base[0]), 32'd32);
        chk("lap err", 32'(err_jump[0]), 32'd0);
        chk("lap final bin", 32'(rq_wptr_bin[0]), 32'd0);

        // Latency sweep for STAGES=3 and STAGES=4.
        do_reset();
        wptr_s[0] = 5'b00001;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            chk($sformatf("s3 rq e%0d", e), 32'(rq3[0]), (e >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("s3 upd e%0d", e), 32'(upd3[0]), (e == 4) ? 32'd1 : 32'd0);
            chk($sformatf("s4 rq e%0d", e), 32'(rq4[0]), (e >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("s4 upd e%0d", e), 32'(upd4[0]), (e == 5) ? 32'd1 : 32'd0);
        end

        // Illegal jump, clear, then clear colliding with a second jump.
        do_reset();
        wptr[0] = 5'b00011;
        repeat (2) @(negedge clk);
        chk("jump e2 err", 32'(err_jump[0]), 32'd0);
        @(negedge clk);
        chk("jump e3 err", 32'(err_jump[0]), 32'd1);
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        chk("clr err", 32'(err_jump[0]), 32'd0);
        wptr[0] = 5'b01100;
        repeat (2) @(negedge clk);
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        chk("set wins err", 32'(err_jump[0]), 32'd1);
        @(negedge clk);
        chk("set wins hold", 32'(err_jump[0]), 32'd1);

        // Channel isolation.
        do_reset();
        for (int c = 0; c < CH; c++) base[c] = cnt[c];
        wptr[2] = 5'b00001;
        wptr[0] = 5'b00011;
        repeat (6) @(negedge clk);
        chk("iso upd ch0", 32'(cnt[0] - base[0]), 32'd1);
        chk("iso upd ch1", 32'(cnt[1] - base[1]), 32'd0);
        chk("iso upd ch2", 32'(cnt[2] - base[2]), 32'd1);
        chk("iso upd ch3", 32'(cnt[3] - base[3]), 32'd0);
        chk("iso err", 32'(err_jump), 32'b0001);
        chk("iso bin ch2", 32'(rq_wptr_bin[2]), 32'd1);

        // Reset asserted mid-run.
        do_reset();
        wptr[0] = 5'b01100;
        waited = 0;
        while (rq_wptr[0] != 5'b01100 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("midrst reach timeout", 32'(rq_wptr[0]), 32'b01100);
        #2;
        rst_n = 1'b0;
        wptr  = '0;
        #1;
        chk("midrst rq_wptr", 32'(rq_wptr), 32'd0);
        chk("midrst bin", 32'(rq_wptr_bin), 32'd0);
        chk("midrst upd", 32'(rq_upd), 32'd0);
        chk("midrst err", 32'(err_jump), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < CH; c++) base[c] = cnt[c];
        repeat (6) @(negedge clk);
        chk("midrst no upd", 32'((cnt[0] - base[0]) + (cnt[1] - base[1]) + (cnt[2] - base[2]) + (cnt[3] - base[3])), 32'd0);
        chk("midrst rq after", 32'(rq_wptr[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
